// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, constants and types for the PWM output bank.
// Imported by pwm_timebase and pwm_output_bank.
package pwm_pkg;

  localparam int CNT_W   = 8;
  localparam int DIV_W   = 4;
  localparam int NUM_GEN = 4;
  localparam int NUM_OUT = 8;

  localparam logic [CNT_W-1:0] DUTY_ALWAYS_HIGH = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX          = 8'hFF;

  typedef logic [1:0] sel_t;

  // 255 is full-on so that "always high" has no single low tick
  function automatic logic gen_level(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] duty
  );
    return (duty == DUTY_ALWAYS_HIGH) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared prescaler and 8-bit period counter.
// Emits tick, period boundary and the post-reset first-tick flag.
module pwm_timebase
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_in,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             boundary,
  output logic             first
);

  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_sh;

  assign tick     = (presc == div_sh);
  assign boundary = tick && (cnt == CNT_MAX);

  // Prescaler, period counter and divider shadow load
  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      cnt    <= '0;
      div_sh <= '0;
      first  <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        cnt <= cnt + 1'b1;
      end
      if (boundary || (tick && first)) begin
        div_sh <= div_in;
        first  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_output_bank.sv
// pwm_output_bank: 4 shadowed PWM generators and an 8-output crossbar.
// Build option PWM_PERIOD_STROBE_EN adds the period_strobe output.
module pwm_output_bank
  import pwm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_OUT-1:0] reg_en_out,
  input  logic [NUM_OUT-1:0] reg_en_pwm_out,
  input  logic [7:0]         reg_out_3_0_pwm_chanel,
  input  logic [7:0]         reg_out_7_4_pwm_chanel,
  input  logic [CNT_W-1:0]   reg_pwm_gen_1_duty_cycle,
  input  logic [CNT_W-1:0]   reg_pwm_gen_2_duty_cycle,
  input  logic [CNT_W-1:0]   reg_pwm_gen_3_duty_cycle,
  input  logic [CNT_W-1:0]   reg_pwm_gen_4_duty_cycle,
  input  logic [DIV_W-1:0]   reg_pwm_frequency_divider,
  output logic [NUM_OUT-1:0] pwm_out
`ifdef PWM_PERIOD_STROBE_EN
  ,
  output logic               period_strobe
`endif
);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             boundary;
  logic             first;
  logic             load;

  logic [NUM_GEN-1:0][CNT_W-1:0] duty_in;
  logic [NUM_GEN-1:0][CNT_W-1:0] duty_sh;
  logic [NUM_GEN-1:0]            pwm;
  logic [15:0]                   sel_all;
  logic [NUM_OUT-1:0]            nxt;

  pwm_timebase u_tb (
    .clk      (clk),
    .rst      (rst),
    .div_in   (reg_pwm_frequency_divider),
    .cnt      (cnt),
    .tick     (tick),
    .boundary (boundary),
    .first    (first)
  );

  assign load    = boundary || (tick && first);
  assign sel_all = {reg_out_7_4_pwm_chanel, reg_out_3_0_pwm_chanel};
  assign duty_in = {reg_pwm_gen_4_duty_cycle,
                    reg_pwm_gen_3_duty_cycle,
                    reg_pwm_gen_2_duty_cycle,
                    reg_pwm_gen_1_duty_cycle};

  // Duty shadows follow the inputs only at a period boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh <= '0;
    end else if (load) begin
      duty_sh <= duty_in;
    end
  end

  // Generator comparators
  always_comb begin
    pwm = '0;
    for (int g = 0; g < NUM_GEN; g++) begin
      pwm[g] = gen_level(cnt, duty_sh[g]);
    end
  end

  // Crossbar: enable, then mode, then selected generator
  always_comb begin
    sel_t sel;
    nxt = '0;
    sel = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      sel = sel_all[2*i +: 2];
      priority case (1'b1)
        !reg_en_out[i]:     nxt[i] = 1'b0;
        !reg_en_pwm_out[i]: nxt[i] = 1'b1;
        default:            nxt[i] = pwm[sel];
      endcase
    end
  end

  // Registered pins
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= nxt;
    end
  end

`ifdef PWM_PERIOD_STROBE_EN
  logic bnd_q;

  // Strobe lines up with the pin cycle that shows cnt=0
  always_ff @(posedge clk) begin
    if (rst) begin
      bnd_q         <= 1'b0;
      period_strobe <= 1'b0;
    end else begin
      bnd_q         <= boundary;
      period_strobe <= bnd_q;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_output_bank.sv
// tb_pwm_output_bank: randomized and directed checks of pwm_output_bank
// against a tick-level behavioural model.
module tb_pwm_output_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] en, mode, ch30, ch74;
  logic [7:0] d1, d2, d3, d4;
  logic [3:0] div;
  logic [7:0] pwm_out;
`ifdef PWM_PERIOD_STROBE_EN
  logic       period_strobe;
`endif

  always #5 clk = ~clk;

  pwm_output_bank dut (
    .clk                       (clk),
    .rst                       (rst),
    .reg_en_out                (en),
    .reg_en_pwm_out            (mode),
    .reg_out_3_0_pwm_chanel    (ch30),
    .reg_out_7_4_pwm_chanel    (ch74),
    .reg_pwm_gen_1_duty_cycle  (d1),
    .reg_pwm_gen_2_duty_cycle  (d2),
    .reg_pwm_gen_3_duty_cycle  (d3),
    .reg_pwm_gen_4_duty_cycle  (d4),
    .reg_pwm_frequency_divider (div),
    .pwm_out                   (pwm_out)
`ifdef PWM_PERIOD_STROBE_EN
    ,
    .period_strobe             (period_strobe)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Model: clocks elapsed within the current tick, tick index in
  // the period, and the duty/divider values governing this period
  int         m_clk_in_tick;
  int         m_pos;
  int         m_div;
  int         m_duty [4];
  bit         m_fresh;
  bit         m_bnd_seen;
  bit         m_strobe;
  logic [7:0] m_out;

  function automatic bit gen_hi(input int g);
    if (m_duty[g] == 255) return 1'b1;
    return m_pos < m_duty[g];
  endfunction

  function automatic int sel_of(input int i);
    if (i < 4) return (int'(ch30) / (4 ** i)) % 4;
    return (int'(ch74) / (4 ** (i - 4))) % 4;
  endfunction

  task automatic model_step();
    bit tick;
    if (rst) begin
      m_clk_in_tick = 0;
      m_pos         = 0;
      m_div         = 0;
      m_duty        = '{0, 0, 0, 0};
      m_fresh       = 1'b1;
      m_bnd_seen    = 1'b0;
      m_strobe      = 1'b0;
      m_out         = '0;
    end else begin
      tick = (m_clk_in_tick == m_div);
      for (int i = 0; i < 8; i++) begin
        if (!en[i])        m_out[i] = 1'b0;
        else if (!mode[i]) m_out[i] = 1'b1;
        else               m_out[i] = gen_hi(sel_of(i));
      end
      m_strobe   = m_bnd_seen;
      m_bnd_seen = tick && (m_pos == 255);
      if (tick && (m_pos == 255 || m_fresh)) begin
        m_duty  = '{int'(d1), int'(d2), int'(d3), int'(d4)};
        m_div   = int'(div);
        m_fresh = 1'b0;
      end
      if (tick) begin
        m_clk_in_tick = 0;
        m_pos         = (m_pos + 1) % 256;
      end else begin
        m_clk_in_tick++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pwm_out", pwm_out, m_out);
`ifdef PWM_PERIOD_STROBE_EN
    chk("strobe", period_strobe, m_strobe);
`endif
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic count_hi(input int idx, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      step();
      hi += int'(pwm_out[idx]);
    end
  endtask

  task automatic wait_rise(input int idx, input int budget, output int n);
    logic prev;
    prev = pwm_out[idx];
    n = 0;
    while (n < budget) begin
      step();
      n++;
      if (!prev && pwm_out[idx]) break;
      prev = pwm_out[idx];
    end
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (m_pos != p && k < 5000) begin
      step();
      k++;
    end
    if (k >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL sync: waited %0d clk for cnt %0d", k, p);
    end
  endtask

  int hi;
  int n1, n2;
  int hs [8];
  int exp_hs [8];

  initial begin
    rst  = 1'b1;
    en   = '0; mode = '0; ch30 = '0; ch74 = '0;
    d1   = '0; d2 = '0; d3 = '0; d4 = '0;
    div  = '0;

    run(3);
    chk("reset_out", pwm_out, 8'h00);
    rst = 1'b0;
    run(5);
    chk("idle_out", pwm_out, 8'h00);

    en = 8'hFF;
    step();
    chk("static_high", pwm_out, 8'hFF);

    en = 8'h01; mode = 8'h01; d1 = 8'd64;
    run(600);
    count_hi(0, 256, hi);
    chk("duty64", hi, 64);

    d1 = 8'd0;
    run(300);
    count_hi(0, 768, hi);
    chk("duty0", hi, 0);

    d1 = 8'd255;
    run(300);
    count_hi(0, 768, hi);
    chk("duty255", hi, 768);

    div = 4'd3; d1 = 8'd128;
    run(1300);
    count_hi(0, 1024, hi);
    chk("presc_high", hi, 512);
    wait_rise(0, 3000, n1);
    wait_rise(0, 3000, n2);
    chk("presc_period", n2, 1024);

    div = 4'd0; d1 = 8'd64;
    run(1300);
    wait_pos(100);
    d1 = 8'd200;
    count_hi(0, 150, hi);
    chk("shadow_hold", hi, 0);
    run(10);
    count_hi(0, 256, hi);
    chk("shadow_next", hi, 200);

    d1 = 8'd128;
    run(600);
    wait_pos(100);
    div = 4'd7;
    wait_rise(0, 5000, n1);
    chk("div_hold", n1, 157);
    wait_rise(0, 5000, n2);
    chk("div_next", n2, 2048);

    div = 4'd0;
    d1 = 8'd32; d2 = 8'd64; d3 = 8'd96; d4 = 8'd128;
    ch30 = 8'hE4; ch74 = 8'h1B;
    en = 8'hFF; mode = 8'hFF;
    run(2600);
    hs = '{0, 0, 0, 0, 0, 0, 0, 0};
    repeat (256) begin
      step();
      for (int i = 0; i < 8; i++) hs[i] += int'(pwm_out[i]);
    end
    exp_hs = '{32, 64, 96, 128, 128, 96, 64, 32};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("xbar_out%0d", i), hs[i], exp_hs[i]);
    end

    wait_pos(20);
    en = 8'hDF;
    step();
    chk("en5_off", pwm_out[5], 1'b0);
    en = 8'hFF;

    wait_pos(150);
    rst = 1'b1;
    step();
    chk("rst_mid", pwm_out, 8'h00);
    rst = 1'b0;
    wait_rise(3, 400, n1);
    chk("rst_restart", n1, 2);

`ifdef PWM_PERIOD_STROBE_EN
    div = 4'd1;
    run(1100);
    n1 = 0;
    while (!period_strobe && n1 < 2000) begin
      step();
      n1++;
    end
    step();
    chk("strobe_width", period_strobe, 1'b0);
    n2 = 1;
    while (!period_strobe && n2 < 2000) begin
      step();
      n2++;
    end
    chk("strobe_period", n2, 512);
`endif

    for (int s = 0; s < 24; s++) begin
      en   = 8'($urandom);
      mode = 8'($urandom);
      ch30 = 8'($urandom);
      ch74 = 8'($urandom);
      d1   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      d2   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d3   = 8'($urandom);
      d4   = 8'($urandom);
      div  = 4'($urandom_range(0, 2));
      rst  = ($urandom_range(0, 7) == 0);
      step();
      rst  = 1'b0;
      run($urandom_range(20, 400));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
